// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO between the frame producer and the VGA timing stage, with a prefill-gated stream FSM.
// Optional underrun counter is enabled by defining VGA_PIXEL_FIFO_UNDERRUN_CNT_EN.
module vga_pixel_fifo #(
    parameter int DW      = 12,
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_valid,
    input  logic [DW-1:0]            i_wr_data,
    output logic                     o_wr_ready,
    input  logic                     i_pix_stb,
    input  logic                     i_video_on,
    input  logic                     i_frame_start,
    output logic [DW-1:0]            o_rgb,
    output logic [1:0]               o_state,
    output logic                     o_underflow,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [15:0]              o_underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [DW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic [LW-1:0]   level_nxt_s;
    logic [DW-1:0]   rgb_r;
    logic            underflow_r;
    logic            flush_s;
    logic            wr_ready_s;
    logic            wr_en_s;
    logic            pop_req_s;
    logic            pop_s;
    logic            underrun_s;

    assign flush_s    = (state_r == ST_ERR) && i_frame_start;
    assign wr_ready_s = (level_r != LW'(DEPTH)) && !flush_s;
    assign wr_en_s    = i_wr_valid && wr_ready_s;
    assign pop_req_s  = i_pix_stb && i_video_on && (state_r == ST_STREAM);
    assign pop_s      = pop_req_s && (level_r != {LW{1'b0}});
    assign underrun_s = pop_req_s && (level_r == {LW{1'b0}});

    // Occupancy update; a write and a pop in the same cycle cancel out.
    always_comb begin
        level_nxt_s = level_r;
        if (flush_s) begin
            level_nxt_s = {LW{1'b0}};
        end else if (wr_en_s && !pop_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (pop_s && !wr_en_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Stream FSM next-state; the unused encoding recovers to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_frame_start && (level_r >= LW'(PREFILL))) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (underrun_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_ERR: begin
                if (i_frame_start) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pixel storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= i_wr_data;
        end
    end

    // Pointers, level, state, output pixel and sticky underflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            state_r     <= ST_IDLE;
            rgb_r       <= {DW{1'b0}};
            underflow_r <= 1'b0;
        end else begin
            level_r <= level_nxt_s;
            state_r <= state_nxt_s;
            if (flush_s) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (wr_en_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
            end
            // Blank on any strobe that does not deliver a pixel, including underruns.
            if (i_pix_stb) begin
                rgb_r <= pop_s ? mem_r[rd_ptr_r] : {DW{1'b0}};
            end
            if (underrun_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

`ifdef VGA_PIXEL_FIFO_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_r;

    // Saturating underrun event counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            underrun_cnt_r <= 16'd0;
        end else if (underrun_s && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'd1;
        end
    end

    assign o_underrun_cnt = underrun_cnt_r;
`else
    assign o_underrun_cnt = 16'd0;
`endif

    assign o_wr_ready  = wr_ready_s;
    assign o_rgb       = rgb_r;
    assign o_state     = state_r;
    assign o_underflow = underflow_r;
    assign o_level     = level_r;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Randomized and directed bench for vga_pixel_fifo against a queue-based reference model.
module tb_vga_pixel_fifo;

    localparam int DW      = 12;
    localparam int DEPTH   = 16;
    localparam int PREFILL = 8;

    logic          clk;
    logic          i_rst;
    logic          i_wr_valid;
    logic [DW-1:0] i_wr_data;
    logic          o_wr_ready;
    logic          i_pix_stb;
    logic          i_video_on;
    logic          i_frame_start;
    logic [DW-1:0] o_rgb;
    logic [1:0]    o_state;
    logic          o_underflow;
    logic [4:0]    o_level;
    logic [15:0]   o_underrun_cnt;

    int n_tests;
    int n_fail;

    logic [DW-1:0] q[$];
    int            m_state;
    bit            m_uf;
    int            m_cnt;
    logic [DW-1:0] m_rgb;

    vga_pixel_fifo #(.DW(DW), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_wr_valid     (i_wr_valid),
        .i_wr_data      (i_wr_data),
        .o_wr_ready     (o_wr_ready),
        .i_pix_stb      (i_pix_stb),
        .i_video_on     (i_video_on),
        .i_frame_start  (i_frame_start),
        .o_rgb          (o_rgb),
        .o_state        (o_state),
        .o_underflow    (o_underflow),
        .o_level        (o_level),
        .o_underrun_cnt (o_underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("rgb", 32'(o_rgb), 32'(m_rgb));
        chk("state", 32'(o_state), 32'(m_state));
        chk("underflow", 32'(o_underflow), 32'(m_uf));
        chk("level", 32'(o_level), 32'(q.size()));
        chk("underrun_cnt", 32'(o_underrun_cnt), 32'(m_cnt));
    endtask

    // One clock: drive inputs, check ready, advance model, check registered outputs.
    task automatic cyc(input bit rst, input bit wv, input logic [DW-1:0] wd,
                       input bit stb, input bit von, input bit fs);
        int size0;
        bit ready;
        bit pop_req;
        bit under;
        i_rst = rst; i_wr_valid = wv; i_wr_data = wd;
        i_pix_stb = stb; i_video_on = von; i_frame_start = fs;
        #1;
        size0 = q.size();
        ready = (size0 != DEPTH) && !(m_state == 2 && fs);
        chk("wr_ready", 32'(o_wr_ready), 32'(ready));
        if (rst) begin
            q.delete();
            m_state = 0; m_uf = 0; m_cnt = 0; m_rgb = '0;
        end else begin
            pop_req = stb && von && (m_state == 1);
            under   = pop_req && (size0 == 0);
            if (stb) begin
                if (pop_req && size0 > 0) m_rgb = q.pop_front();
                else m_rgb = '0;
            end
            if (wv && ready) q.push_back(wd);
            case (m_state)
                0: if (fs && size0 >= PREFILL) m_state = 1;
                1: if (under) m_state = 2;
                2: if (fs) begin q.delete(); m_state = 0; end
                default: m_state = 0;
            endcase
            if (under) begin
                m_uf = 1;
`ifdef VGA_PIXEL_FIFO_UNDERRUN_CNT_EN
                if (m_cnt < 65535) m_cnt++;
`endif
            end
        end
        @(posedge clk);
        #1;
        chk_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        cyc(0, 1, d, 0, 0, 0);
    endtask

    // Strobe followed by three quiet cycles, mimicking the 25 MHz pixel rate.
    task automatic pix(input bit von, input bit fs);
        cyc(0, 0, '0, 1, von, fs);
        idle(3);
    endtask

    task automatic do_reset();
        cyc(1, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        int phase;
        bit stb;
        bit von;
        bit fs;
        bit wv;
        bit rst;
        n_tests = 0; n_fail = 0;
        q.delete(); m_state = 0; m_uf = 0; m_cnt = 0; m_rgb = '0;
        i_rst = 1'b1; i_wr_valid = 1'b0; i_wr_data = '0;
        i_pix_stb = 1'b0; i_video_on = 1'b0; i_frame_start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_outputs();
        chk("reset_ready", 32'(o_wr_ready), 32'd1);

        // Prefill then stream in order with 1-clock latency.
        for (int i = 1; i <= 8; i++) wr(DW'(i));
        pix(1, 1);
        chk("stream_entered", 32'(o_state), 32'd1);
        cyc(0, 0, '0, 1, 1, 0);
        chk("first_pixel", 32'(o_rgb), 32'h001);
        chk("level_after_pop", 32'(o_level), 32'd7);
        idle(3);
        pix(1, 0);
        chk("second_pixel", 32'(o_rgb), 32'h002);
        pix(0, 0);
        chk("blank_on_inactive", 32'(o_rgb), 32'h000);

        // Below prefill: frame start ignored.
        do_reset();
        for (int i = 1; i <= 5; i++) wr(DW'(i + 16'h40));
        pix(1, 1);
        chk("idle_below_prefill", 32'(o_state), 32'd0);
        chk("level5", 32'(o_level), 32'd5);

        // Full FIFO, 17th write ignored, pop with write held.
        do_reset();
        for (int i = 0; i < 17; i++) wr(DW'(16'h100 + i));
        chk("full_level", 32'(o_level), 32'd16);
        chk("full_ready", 32'(o_wr_ready), 32'd0);
        pix(1, 1);
        cyc(0, 1, 12'hABC, 1, 1, 0);
        chk("pop_full_level", 32'(o_level), 32'd15);
        cyc(0, 1, 12'hABC, 0, 0, 0);
        chk("refill_level", 32'(o_level), 32'd16);
        for (int i = 0; i < 17; i++) pix(1, 0);

        // Drain to one pixel, then underrun, then ERR writes and flush.
        do_reset();
        for (int i = 1; i <= 8; i++) wr(DW'(16'h200 + i));
        pix(1, 1);
        for (int i = 0; i < 7; i++) pix(1, 0);
        chk("one_left", 32'(o_level), 32'd1);
        pix(1, 0);
        pix(1, 0);
        chk("underrun_rgb", 32'(o_rgb), 32'd0);
        chk("underrun_flag", 32'(o_underflow), 32'd1);
        chk("underrun_state", 32'(o_state), 32'd2);
        for (int i = 0; i < 3; i++) wr(DW'(16'h300 + i));
        chk("err_writes", 32'(o_level), 32'd3);
        pix(1, 1);
        chk("flush_level", 32'(o_level), 32'd0);
        chk("flush_state", 32'(o_state), 32'd0);
        chk("sticky_uf", 32'(o_underflow), 32'd1);

        // Reset mid-stream with level 6.
        do_reset();
        for (int i = 1; i <= 8; i++) wr(DW'(16'h400 + i));
        pix(1, 1);
        pix(1, 0);
        pix(1, 0);
        chk("level6", 32'(o_level), 32'd6);
        cyc(1, 0, '0, 0, 0, 0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_rgb", 32'(o_rgb), 32'd0);
        chk("rst_uf", 32'(o_underflow), 32'd0);

        // Randomized traffic with varying producer rate.
        for (int c = 0; c < 6000; c++) begin
            phase = (c / 500) % 3;
            stb = (c % 4) == 0;
            von = stb ? ($urandom_range(0, 7) != 0) : $urandom_range(0, 1) == 1;
            fs  = stb && ($urandom_range(0, 29) == 0);
            case (phase)
                0:       wv = $urandom_range(0, 9) != 0;
                1:       wv = $urandom_range(0, 9) < 3;
                default: wv = $urandom_range(0, 9) == 0;
            endcase
            rst = $urandom_range(0, 1499) == 0;
            cyc(rst, wv, DW'($urandom), stb, von, fs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fifo.md
VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

Interface
REQ-001 Parameter DW, default 12, pixel width (4-bit R, G, B, packed {R,G,B}).
REQ-002 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, at least 4.
REQ-003 Parameter PREFILL, default 8, minimum fill level required to start streaming; SHALL satisfy 1 <= PREFILL <= DEPTH.
REQ-004 i_clk  input  1  system clock (100 MHz); all logic SHALL be clocked on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_wr_valid  input  1  producer presents a pixel.
REQ-007 i_wr_data  input  DW  pixel data.
REQ-008 o_wr_ready  output  1  FIFO accepts; a write occurs when i_wr_valid and o_wr_ready are both high.
REQ-009 i_pix_stb  input  1  one-cycle 25 MHz pixel strobe from the timing stage.
REQ-010 i_video_on  input  1  active-area flag from the timing stage, sampled with i_pix_stb.
REQ-011 i_frame_start  input  1  one-cycle pulse coincident with i_pix_stb at the first active pixel of a frame.
REQ-012 o_rgb  output  DW  registered pixel data to the timing stage.
REQ-013 o_state  output  2  current FSM state (IDLE=0, STREAM=1, ERR=2).
REQ-014 o_underflow  output  1  sticky underrun flag.
REQ-015 o_level  output  log2(DEPTH)+1  current occupancy.
REQ-016 o_underrun_cnt  output  16  underrun event count (see Configuration).

Function
REQ-017 Storage SHALL be a circular buffer with wrapping read/write pointers and an occupancy counter 0..DEPTH.
REQ-018 o_wr_ready SHALL be computed as level != DEPTH, gated low in the flush cycle (REQ-026).
REQ-019 A pop request SHALL be defined as i_pix_stb & i_video_on & (state == STREAM).
REQ-020 On a pop request with level > 0, the head entry SHALL be popped and registered onto o_rgb on the next clock edge, giving 1-clock latency after the strobe.
REQ-021 On every i_pix_stb that is not a successful pop, o_rgb SHALL load 0. Between strobes, o_rgb SHALL hold its value.
REQ-022 A simultaneous write and pop SHALL leave the level unchanged. A pop when full frees an entry, but o_wr_ready SHALL remain low in that cycle.
REQ-023 A pop request with level == 0 is an underrun. An underrun SHALL:
  - drive o_rgb to 0;
  - set o_underflow;
  - take the FSM to ERR.
  There SHALL be no write-to-read pass-through, even if a write occurs in the same cycle.
REQ-024 IDLE: the FSM SHALL go to STREAM on i_frame_start when level >= PREFILL; otherwise it stays in IDLE.
REQ-025 STREAM: i_frame_start SHALL have no effect; an underrun SHALL go to ERR.
REQ-026 ERR: writes SHALL continue to be accepted. On i_frame_start, the FIFO SHALL flush (pointers and level to 0), o_wr_ready SHALL be low in that cycle, and the FSM SHALL go to IDLE.
REQ-027 The encoding value 3 is illegal; if reached, the FSM SHALL go to IDLE.
REQ-028 o_underflow SHALL clear only on reset.

Reset
REQ-029 When i_rst is high at a clock edge, the block SHALL set:
  - pointers = 0, level = 0;
  - state = IDLE;
  - o_rgb = 0, o_underflow = 0, o_underrun_cnt = 0.
REQ-030 Reset SHALL take priority over all other events. A reset mid-stream SHALL discard all stored pixels. o_wr_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-031 Macro VGA_PIXEL_FIFO_UNDERRUN_CNT_EN controls the underrun counter.
  - Defined: o_underrun_cnt SHALL increment by 1 on each underrun, saturate at 16'hFFFF, and clear only on reset.
  - Undefined: o_underrun_cnt SHALL be tied to 0 and no counter logic SHALL be instantiated; all other behaviour is identical.

Verification
REQ-032 Reset, then write 8 pixels 12'h001..12'h008, then i_frame_start with i_video_on -> STREAM. On successive strobes, o_rgb = 001, 002, ... appearing 1 clk after each strobe, and o_level decrements accordingly.
REQ-033 Write 5 pixels (< PREFILL), then i_frame_start -> FSM stays IDLE, o_rgb = 0, o_level = 5.
REQ-034 Write 16 pixels -> o_wr_ready = 0 and a 17th write is ignored. A pop with i_wr_valid held -> level 15 after the pop, and the write is accepted the next cycle -> level 16.
REQ-035 STREAM with 1 pixel left, two active strobes -> second strobe gives o_rgb = 0, o_underflow = 1, o_state = 2, and o_underrun_cnt = 1 with the macro defined (0 without).
REQ-036 In ERR, write 3 pixels, then i_frame_start -> o_level = 0, o_state = 0, o_wr_ready = 0 in the pulse cycle, and o_underflow stays 1.
REQ-037 Assert i_rst mid-STREAM with level 6 -> next cycle o_level = 0, o_state = 0, o_rgb = 0, o_underflow = 0.
